// File: rtl/axi_rd_burst_master_pkg.sv
// Shared definitions for the DDR2 AXI read path: FSM state encoding, AXI response codes
// and the DDR row size helper.
package axi_rd_burst_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_AR,
      ST_R,
      ST_DONE
   } rd_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // A DDR row spans 2**col_bits beats.
   function automatic int row_beats(input int col_bits);
      return 1 << col_bits;
   endfunction

endpackage

// File: rtl/axi_burst_split.sv
// Burst sizing: the largest burst that fits the remaining length, the burst limit and the
// space left in the current DDR row.
module axi_burst_split
   import axi_rd_burst_master_pkg::*;
#(
   parameter int LEN_WIDTH = 16,
   parameter int MAX_BURST = 8,
   parameter int COL_BITS  = 10
) (
   input  logic [LEN_WIDTH-1:0] remain,
   input  logic [COL_BITS-1:0]  col_offset,
   output logic [8:0]           beats
);

   localparam int ROW_BEATS = row_beats(COL_BITS);
   localparam int CW0       = (LEN_WIDTH > COL_BITS + 1) ? LEN_WIDTH : COL_BITS + 1;
   localparam int CW        = (CW0 > 9) ? CW0 : 9;

   logic [CW-1:0] rem_w;
   logic [CW-1:0] space_w;
   logic [CW-1:0] min_w;

   always_comb begin
      rem_w   = CW'(remain);
      space_w = CW'(ROW_BEATS) - CW'(col_offset);
      min_w   = CW'(MAX_BURST);
      if (rem_w < min_w) begin
         min_w = rem_w;
      end
      if (space_w < min_w) begin
         min_w = space_w;
      end
   end

   assign beats = 9'(min_w);

endmodule

// File: rtl/axi_rd_burst_master.sv
// AXI4 read master for the DDR2 user side: splits one user read into row-safe bursts,
// one outstanding at a time, and returns data with backpressure plus a done/error status.
module axi_rd_burst_master
   import axi_rd_burst_master_pkg::*;
#(
   parameter int ADDR_WIDTH = 26,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int MAX_BURST  = 8,
   parameter int COL_BITS   = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [LEN_WIDTH-1:0]  rd_len,
   output logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_data_valid,
   input  logic                  rd_data_ready,
   output logic                  rd_data_last,
   output logic                  rd_done,
   output logic                  rd_err,
   output logic                  axi_arvalid,
   input  logic                  axi_arready,
   output logic [ADDR_WIDTH-1:0] axi_araddr,
   output logic [7:0]            axi_arlen,
   input  logic                  axi_rvalid,
   output logic                  axi_rready,
   input  logic [DATA_WIDTH-1:0] axi_rdata,
   input  logic [1:0]            axi_rresp,
   input  logic                  axi_rlast
);

   rd_state_e state, state_nxt;

   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [LEN_WIDTH-1:0]  remain;
   logic [8:0]            beats;
   logic [8:0]            split_beats;
   logic [7:0]            beat_cnt;
   logic                  err;
   logic                  beat_xfer;
   logic                  last_beat;
   logic                  final_burst;

   axi_burst_split #(
      .LEN_WIDTH (LEN_WIDTH),
      .MAX_BURST (MAX_BURST),
      .COL_BITS  (COL_BITS)
   ) u_split (
      .remain     (remain),
      .col_offset (cur_addr[COL_BITS-1:0]),
      .beats      (split_beats)
   );

   assign rd_ready      = (state == ST_IDLE);
   assign axi_rready    = (state == ST_R) && rd_data_ready;
   assign rd_data_valid = (state == ST_R) && axi_rvalid;
   assign rd_data       = axi_rdata;
   assign beat_xfer     = rd_data_valid && rd_data_ready;
   assign last_beat     = (beat_cnt == 8'd0);
   assign final_burst   = (remain == LEN_WIDTH'(beats));
   assign rd_data_last  = rd_data_valid && last_beat && final_burst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (rd_req) begin
               state_nxt = (rd_len == '0) ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: state_nxt = ST_AR;
         ST_AR: begin
            if (axi_arready) begin
               state_nxt = ST_R;
            end
         end
         ST_R: begin
            if (beat_xfer && last_beat) begin
               state_nxt = final_burst ? ST_DONE : ST_CALC;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Error is sticky across all bursts of a request and only cleared on a new accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_addr    <= '0;
         remain      <= '0;
         beats       <= '0;
         beat_cnt    <= '0;
         err         <= 1'b0;
         axi_arvalid <= 1'b0;
         axi_araddr  <= '0;
         axi_arlen   <= '0;
         rd_done     <= 1'b0;
         rd_err      <= 1'b0;
      end else begin
         rd_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rd_req) begin
                  cur_addr <= rd_addr;
                  remain   <= rd_len;
                  err      <= 1'b0;
               end
            end
            ST_CALC: begin
               beats       <= split_beats;
               axi_araddr  <= cur_addr;
               axi_arlen   <= 8'(split_beats - 9'd1);
               axi_arvalid <= 1'b1;
            end
            ST_AR: begin
               if (axi_arready) begin
                  axi_arvalid <= 1'b0;
                  beat_cnt    <= 8'(beats - 9'd1);
               end
            end
            ST_R: begin
               if (beat_xfer) begin
                  err <= err | (axi_rresp != RESP_OKAY) | (axi_rlast != last_beat);
                  if (last_beat) begin
                     remain   <= remain - LEN_WIDTH'(beats);
                     cur_addr <= cur_addr + ADDR_WIDTH'(beats);
                  end else begin
                     beat_cnt <= beat_cnt - 8'd1;
                  end
               end
            end
            ST_DONE: begin
               rd_done <= 1'b1;
               rd_err  <= err;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Directed bench for axi_rd_burst_master: AXI slave model plus scoreboard of expected
// AR requests and user beats, filled when each request is issued.
module tb_axi_rd_burst_master;

   logic        clk;
   logic        rst;
   logic        rd_req;
   logic [25:0] rd_addr;
   logic [15:0] rd_len;
   logic        rd_ready;
   logic [31:0] rd_data;
   logic        rd_data_valid;
   logic        rd_data_ready;
   logic        rd_data_last;
   logic        rd_done;
   logic        rd_err;
   logic        axi_arvalid;
   logic        axi_arready;
   logic [25:0] axi_araddr;
   logic [7:0]  axi_arlen;
   logic        axi_rvalid;
   logic        axi_rready;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rlast;

   typedef struct {
      logic [25:0] addr;
      logic [7:0]  len;
   } ar_t;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } beat_t;

   ar_t   exp_ar[$];
   ar_t   rq[$];
   beat_t exp_data[$];

   int n_checks = 0;
   int n_fail   = 0;
   int ar_delay = 0;
   int ar_wait  = 0;
   int pos      = 0;
   int gbeat    = 0;
   int resp_err_beat  = 0;
   int rlast_err_beat = 0;
   bit sink_toggle = 0;
   bit rv_toggle   = 0;

   axi_rd_burst_master #(
      .ADDR_WIDTH (26),
      .DATA_WIDTH (32),
      .LEN_WIDTH  (16),
      .MAX_BURST  (8),
      .COL_BITS   (10)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rd_req        (rd_req),
      .rd_addr       (rd_addr),
      .rd_len        (rd_len),
      .rd_ready      (rd_ready),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .rd_data_ready (rd_data_ready),
      .rd_data_last  (rd_data_last),
      .rd_done       (rd_done),
      .rd_err        (rd_err),
      .axi_arvalid   (axi_arvalid),
      .axi_arready   (axi_arready),
      .axi_araddr    (axi_araddr),
      .axi_arlen     (axi_arlen),
      .axi_rvalid    (axi_rvalid),
      .axi_rready    (axi_rready),
      .axi_rdata     (axi_rdata),
      .axi_rresp     (axi_rresp),
      .axi_rlast     (axi_rlast)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] beat_data(input logic [25:0] a);
      return 32'hD000_0000 ^ {6'd0, a};
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference split: min(remaining, 8, space left in the 1024-beat row).
   task automatic model_request(input logic [25:0] addr, input int len);
      logic [25:0] a;
      int rem;
      int b;
      int sp;
      a   = addr;
      rem = len;
      while (rem > 0) begin
         b  = (rem > 8) ? 8 : rem;
         sp = 1024 - int'(a % 26'd1024);
         if (b > sp) b = sp;
         exp_ar.push_back('{a, 8'(b - 1)});
         for (int k = 0; k < b; k++) begin
            exp_data.push_back('{beat_data(a + 26'(k)), (rem == b) && (k == b - 1)});
         end
         a   = a + 26'(b);
         rem = rem - b;
      end
   endtask

   // AXI slave, user sink and scoreboard checks; inputs driven on the falling edge.
   initial begin
      logic [25:0] a;
      axi_arready   = 1'b0;
      axi_rvalid    = 1'b0;
      axi_rdata     = '0;
      axi_rresp     = 2'b00;
      axi_rlast     = 1'b0;
      rd_data_ready = 1'b1;
      forever begin
         @(negedge clk);
         axi_arready   = axi_arvalid && (ar_wait >= ar_delay);
         rd_data_ready = sink_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
         if (rq.size() > 0 && (!rv_toggle || $urandom_range(0, 1) == 1)) begin
            a          = rq[0].addr + 26'(pos);
            axi_rvalid = 1'b1;
            axi_rdata  = beat_data(a);
            axi_rresp  = (gbeat + 1 == resp_err_beat) ? 2'b10 : 2'b00;
            axi_rlast  = (pos == int'(rq[0].len)) || (gbeat + 1 == rlast_err_beat);
         end else begin
            axi_rvalid = 1'b0;
            axi_rdata  = '0;
            axi_rresp  = 2'b00;
            axi_rlast  = 1'b0;
         end
         #1;
         if (axi_arvalid) begin
            if (exp_ar.size() == 0) begin
               check_output("ar_unexpected", 32'(axi_arvalid), 32'd0);
            end else begin
               check_output("araddr", 32'(axi_araddr), 32'(exp_ar[0].addr));
               check_output("arlen", 32'(axi_arlen), 32'(exp_ar[0].len));
            end
            if (axi_arready) begin
               ar_wait = 0;
               if (exp_ar.size() > 0) void'(exp_ar.pop_front());
               rq.push_back('{axi_araddr, axi_arlen});
            end else begin
               ar_wait++;
            end
         end
         if (axi_rvalid && axi_rready && rq.size() > 0) begin
            gbeat++;
            pos++;
            if (pos > int'(rq[0].len)) begin
               void'(rq.pop_front());
               pos = 0;
            end
         end
         if (rd_data_valid && rd_data_ready) begin
            if (exp_data.size() == 0) begin
               check_output("data_unexpected", 32'(rd_data_valid), 32'd0);
            end else begin
               check_output("rd_data", rd_data, exp_data[0].data);
               check_output("rd_data_last", 32'(rd_data_last), 32'(exp_data[0].last));
               void'(exp_data.pop_front());
            end
         end
      end
   end

   task automatic apply_stimulus(input logic [25:0] addr, input int len);
      @(negedge clk);
      rd_req  = 1'b1;
      rd_addr = addr;
      rd_len  = 16'(len);
      gbeat   = 0;
      model_request(addr, len);
      #1;
      check_output("rd_ready_idle", 32'(rd_ready), 32'd1);
      @(negedge clk);
      rd_req = 1'b0;
      #1;
      check_output("rd_ready_busy", 32'(rd_ready), 32'd0);
      check_output("arvalid_cycle1", 32'(axi_arvalid), 32'd0);
      check_output("done_cycle1", 32'(rd_done), 32'd0);
      @(negedge clk);
      #1;
      if (len != 0) begin
         check_output("arvalid_cycle2", 32'(axi_arvalid), 32'd1);
      end else begin
         check_output("arvalid_empty", 32'(axi_arvalid), 32'd0);
         check_output("done_cycle2", 32'(rd_done), 32'd1);
      end
   endtask

   task automatic finish_request(input logic exp_err);
      for (int i = 0; i < 3000; i++) begin
         if (rd_done) break;
         @(negedge clk);
         #1;
      end
      check_output("rd_done_seen", 32'(rd_done), 32'd1);
      check_output("rd_err", 32'(rd_err), 32'(exp_err));
      @(negedge clk);
      #1;
      check_output("done_pulse", 32'(rd_done), 32'd0);
      check_output("ar_left", 32'(exp_ar.size()), 32'd0);
      check_output("beats_left", 32'(exp_data.size()), 32'd0);
   endtask

   initial begin
      rst     = 1'b1;
      rd_req  = 1'b0;
      rd_addr = '0;
      rd_len  = '0;
      repeat (3) @(negedge clk);
      #1;
      check_output("rst_arvalid", 32'(axi_arvalid), 32'd0);
      check_output("rst_araddr", 32'(axi_araddr), 32'd0);
      check_output("rst_arlen", 32'(axi_arlen), 32'd0);
      check_output("rst_done", 32'(rd_done), 32'd0);
      check_output("rst_err", 32'(rd_err), 32'd0);
      check_output("rst_rready", 32'(axi_rready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_output("rd_ready_after_rst", 32'(rd_ready), 32'd1);

      $display("[TB] T1 single burst");
      apply_stimulus(26'h10, 8);
      finish_request(1'b0);

      $display("[TB] T2 row boundary split");
      apply_stimulus(26'h3FC, 8);
      finish_request(1'b0);

      $display("[TB] T3 multi-burst request");
      apply_stimulus(26'h0, 20);
      finish_request(1'b0);

      $display("[TB] T4 backpressure and delayed arready");
      ar_delay    = 5;
      sink_toggle = 1;
      rv_toggle   = 1;
      apply_stimulus(26'h3F9, 13);
      finish_request(1'b0);
      ar_delay    = 0;
      sink_toggle = 0;
      rv_toggle   = 0;

      $display("[TB] T5 error response and early rlast");
      resp_err_beat = 3;
      apply_stimulus(26'h40, 8);
      finish_request(1'b1);
      resp_err_beat  = 0;
      rlast_err_beat = 5;
      apply_stimulus(26'h80, 8);
      finish_request(1'b1);
      rlast_err_beat = 0;
      apply_stimulus(26'h100, 3);
      finish_request(1'b0);

      $display("[TB] T6 empty request and reset during data phase");
      apply_stimulus(26'h200, 0);
      finish_request(1'b0);

      apply_stimulus(26'h0, 20);
      for (int i = 0; i < 200; i++) begin
         if (rd_data_valid) break;
         @(negedge clk);
         #1;
      end
      check_output("reached_data_phase", 32'(rd_data_valid), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      exp_ar.delete();
      exp_data.delete();
      rq.delete();
      pos     = 0;
      ar_wait = 0;
      #1;
      check_output("midrst_arvalid", 32'(axi_arvalid), 32'd0);
      check_output("midrst_rready", 32'(axi_rready), 32'd0);
      check_output("midrst_done", 32'(rd_done), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check_output("midrst_rd_ready", 32'(rd_ready), 32'd1);
      check_output("midrst_arvalid_after", 32'(axi_arvalid), 32'd0);

      apply_stimulus(26'h3FFFFFE, 5);
      finish_request(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
